// File: rtl/phase_sequencer.sv
// Four-phase non-overlapping pulse sequencer with per-phase dead time,
// frame counting and a stop request that takes effect at the frame boundary.
module phase_sequencer #(
    parameter int CNT_W = 8,
    parameter int FRM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] phase_len,
    input  logic [CNT_W-1:0] dead_len,
    input  logic [FRM_W-1:0] num_frames,
    output logic             p1,
    output logic             p2,
    output logic             p3,
    output logic             p4,
    output logic             p23,
    output logic             busy,
    output logic             frame_done,
    output logic [FRM_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [FRM_W-1:0] FRM_ONE = FRM_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] plen_q, plen_d;
    logic [CNT_W-1:0] dlen_q, dlen_d;
    logic [FRM_W-1:0] nfr_q, nfr_d;
    logic             pend_q, pend_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]       p_q, p_d;
    logic             p23_q, p23_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] start_len_m1;
    logic [CNT_W-1:0] run_len_m1;
    logic [FRM_W-1:0] frame_next;
    logic             stop_seen;
    logic             advance;

    // Phase length of zero behaves as one, so the loaded count saturates at 0.
    assign start_len_m1 = (phase_len == '0) ? '0 : (phase_len - CNT_ONE);
    assign run_len_m1   = (plen_q == '0) ? '0 : (plen_q - CNT_ONE);
    assign frame_next   = frame_cnt_q + FRM_ONE;
    assign stop_seen    = pend_q | stop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            plen_q      <= '0;
            dlen_q      <= '0;
            nfr_q       <= '0;
            pend_q      <= 1'b0;
            frame_cnt_q <= '0;
            p_q         <= '0;
            p23_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            plen_q      <= plen_d;
            dlen_q      <= dlen_d;
            nfr_q       <= nfr_d;
            pend_q      <= pend_d;
            frame_cnt_q <= frame_cnt_d;
            p_q         <= p_d;
            p23_q       <= p23_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        plen_d      = plen_q;
        dlen_d      = dlen_q;
        nfr_d       = nfr_q;
        pend_d      = pend_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        advance     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d     = PHASE;
                    idx_d       = 2'd0;
                    cnt_d       = start_len_m1;
                    plen_d      = phase_len;
                    dlen_d      = dead_len;
                    nfr_d       = num_frames;
                    frame_cnt_d = '0;
                    pend_d      = 1'b0;
                end
            end
            PHASE: begin
                pend_d = stop_seen;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (dlen_q != '0) begin
                    state_d = DEAD;
                    cnt_d   = dlen_q - CNT_ONE;
                end else begin
                    advance = 1'b1;
                end
            end
            DEAD: begin
                pend_d = stop_seen;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase

        // Leaving the last phase closes the frame; the next p1 shares the done cycle.
        if (advance) begin
            if (idx_q != 2'd3) begin
                state_d = PHASE;
                idx_d   = idx_q + 2'd1;
                cnt_d   = run_len_m1;
            end else begin
                done_d      = 1'b1;
                frame_cnt_d = frame_next;
                if (!stop_seen && ((nfr_q == '0) || (frame_next < nfr_q))) begin
                    state_d = PHASE;
                    idx_d   = 2'd0;
                    cnt_d   = run_len_m1;
                end else begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
        end
    end

    always_comb begin
        p_d = '0;
        if (state_d == PHASE) begin
            p_d[idx_d] = 1'b1;
        end
        p23_d  = p_d[1] | p_d[2];
        busy_d = (state_d != IDLE);
    end

    assign p1         = p_q[0];
    assign p2         = p_q[1];
    assign p3         = p_q[2];
    assign p4         = p_q[3];
    assign p23        = p23_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios plus random
// traffic compared every cycle against an arithmetic timeline model.
module tb_phase_sequencer;

    localparam int CNT_W = 8;
    localparam int FRM_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] phaseLen;
    logic [CNT_W-1:0] deadLen;
    logic [FRM_W-1:0] numFrames;
    logic             p1, p2, p3, p4, p23, busy, frameDone;
    logic [FRM_W-1:0] frameCnt;

    phase_sequencer #(.CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .phase_len  (phaseLen),
        .dead_len   (deadLen),
        .num_frames (numFrames),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p4         (p4),
        .p23        (p23),
        .busy       (busy),
        .frame_done (frameDone),
        .frame_cnt  (frameCnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a run is a timeline of frames of length 4*(P+D) starting at cycle 1.
    bit mRun  = 1'b0;
    bit mDone = 1'b0;
    int mT, mP, mD, mL, mNf;
    int mEnd;
    int mCnt  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        logic [3:0] expP;
        int k;
        expP = 4'b0000;
        if (mRun) begin
            k = (mT - 1) % mL;
            if ((k % (mP + mD)) < mP) expP[k / (mP + mD)] = 1'b1;
        end
        checkOutput("p1", 32'(p1), 32'(expP[0]));
        checkOutput("p2", 32'(p2), 32'(expP[1]));
        checkOutput("p3", 32'(p3), 32'(expP[2]));
        checkOutput("p4", 32'(p4), 32'(expP[3]));
        checkOutput("p23", 32'(p23), 32'(expP[1] | expP[2]));
        checkOutput("busy", 32'(busy), 32'(mRun));
        checkOutput("frame_done", 32'(frameDone), 32'(mDone));
        checkOutput("frame_cnt", 32'(frameCnt), 32'(mCnt));
        checkOutput("onehot0", 32'($onehot0({p4, p3, p2, p1})), 32'd1);
        checkOutput("p23_rule", 32'(p23), 32'(p2 | p3));
    endtask

    task automatic modelStep(input bit st, input bit sp);
        int m;
        mDone = 1'b0;
        if (!mRun) begin
            if (st && !sp) begin
                mRun = 1'b1;
                mT   = 1;
                mP   = (phaseLen == 0) ? 1 : int'(phaseLen);
                mD   = int'(deadLen);
                mL   = 4 * (mP + mD);
                mNf  = int'(numFrames);
                mEnd = (mNf == 0) ? 32'h7fffffff : mNf;
                mCnt = 0;
            end
        end else begin
            if (sp) begin
                m = (mT + mL - 1) / mL;
                if (m < mEnd) mEnd = m;
            end
            mT++;
            if ((mT - 1) % mL == 0) begin
                mDone = 1'b1;
                mCnt  = (mCnt + 1) % (1 << FRM_W);
                if ((mT - 1) / mL >= mEnd) mRun = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input bit st, input bit sp, input int pl, input int dl, input int nf);
        start     = st;
        stop      = sp;
        phaseLen  = CNT_W'(pl);
        deadLen   = CNT_W'(dl);
        numFrames = FRM_W'(nf);
        modelStep(st, sp);
        @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
    endtask

    task automatic applyReset();
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
        #1;
        mRun  = 1'b0;
        mDone = 1'b0;
        mCnt  = 0;
        checkAll();
        @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3, 3, 3);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        phaseLen  = '0;
        deadLen   = '0;
        numFrames = '0;
        @(negedge clk);
        applyReset();
        idle(2);

        $display("[TB] single frame, phase 2 dead 1");
        applyStimulus(1'b1, 1'b0, 2, 1, 1);
        for (int i = 2; i <= 14; i++) begin
            applyStimulus(1'b0, 1'b0, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
            if (i == 13) begin
                checkOutput("req032_done13", 32'(frameDone), 32'd1);
                checkOutput("req032_busy13", 32'(busy), 32'd0);
            end
        end
        checkOutput("req032_cnt", 32'(frameCnt), 32'd1);

        $display("[TB] two frames, zero lengths");
        applyStimulus(1'b1, 1'b0, 0, 0, 2);
        idle(11);
        checkOutput("req033_cnt", 32'(frameCnt), 32'd2);

        $display("[TB] continuous run stopped in frame 3");
        applyStimulus(1'b1, 1'b0, 1, 0, 0);
        for (int i = 2; i <= 20; i++) applyStimulus(1'b0, (i == 10), 1, 0, 0);
        checkOutput("req034_cnt", 32'(frameCnt), 32'd3);
        checkOutput("req034_busy", 32'(busy), 32'd0);

        $display("[TB] start with stop, start while busy");
        applyStimulus(1'b1, 1'b1, 1, 0, 0);
        checkOutput("req035_busy", 32'(busy), 32'd0);
        applyStimulus(1'b1, 1'b0, 1, 1, 2);
        for (int i = 2; i <= 20; i++) applyStimulus((i % 3) == 0, 1'b0, 2, 0, 1);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 1'b0, 1, 0, 0);
        applyStimulus(1'b0, 1'b0, 1, 0, 0);
        applyStimulus(1'b0, 1'b0, 1, 0, 0);
        checkOutput("req036_p3", 32'(p3), 32'd1);
        applyReset();
        idle(2);
        applyStimulus(1'b1, 1'b0, 1, 0, 1);
        idle(6);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                applyReset();
            end else begin
                applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                              $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
